// File: rtl/data_sram_axi_bridge_pkg.sv
// Shared AXI constants and FSM encoding for the MEM-stage data SRAM to AXI bridge.
package data_sram_axi_bridge_pkg;

    localparam logic [2:0] AXI_SIZE_WORD  = 3'b010;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [7:0] AXI_LEN_1BEAT  = 8'd0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_ADDR,
        ST_RD_DATA,
        ST_WR_REQ,
        ST_WR_RESP,
        ST_DONE
    } bridge_state_e;

endpackage

// File: rtl/data_sram_axi_bridge.sv
// Turns one MEM-stage SRAM-style read or byte-masked write into a single-beat uncached AXI4
// transaction, stalling the pipeline until it completes and holding the result until MEM advances.
module data_sram_axi_bridge
    import data_sram_axi_bridge_pkg::*;
#(
    parameter logic [3:0] AXI_ID = 4'd1,
    parameter int         ADDR_W = 32,
    parameter int         DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              ram_read_enable_i,
    input  logic [ADDR_W-1:0] ram_read_addr_i,
    input  logic              ram_write_enable_i,
    input  logic [3:0]        ram_write_select_i,
    input  logic [ADDR_W-1:0] ram_write_addr_i,
    input  logic [DATA_W-1:0] ram_write_data_i,
    input  logic              pipeline_stall_i,
    output logic [DATA_W-1:0] ram_read_data_o,
    output logic              data_stall_o,
    // AR channel
    output logic [3:0]        arid,
    output logic [ADDR_W-1:0] araddr,
    output logic [7:0]        arlen,
    output logic [2:0]        arsize,
    output logic [1:0]        arburst,
    output logic              arvalid,
    input  logic              arready,
    // R channel
    input  logic [3:0]        rid,
    input  logic [DATA_W-1:0] rdata,
    input  logic [1:0]        rresp,
    input  logic              rlast,
    input  logic              rvalid,
    output logic              rready,
    // AW channel
    output logic [3:0]        awid,
    output logic [ADDR_W-1:0] awaddr,
    output logic [7:0]        awlen,
    output logic [2:0]        awsize,
    output logic [1:0]        awburst,
    output logic              awvalid,
    input  logic              awready,
    // W channel
    output logic [3:0]        wid,
    output logic [DATA_W-1:0] wdata,
    output logic [3:0]        wstrb,
    output logic              wlast,
    output logic              wvalid,
    input  logic              wready,
    // B channel
    input  logic [3:0]        bid,
    input  logic [1:0]        bresp,
    input  logic              bvalid,
    output logic              bready
);

    bridge_state_e     r_state;
    bridge_state_e     w_next;

    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [3:0]        r_wstrb;
    logic [DATA_W-1:0] r_rdata;

    logic              r_arvalid;
    logic              r_rready;
    logic              r_awvalid;
    logic              r_wvalid;
    logic              r_bready;
    logic              r_aw_done;
    logic              r_w_done;

    logic              w_ar_hs;
    logic              w_r_hs;
    logic              w_aw_hs;
    logic              w_w_hs;
    logic              w_b_hs;
    logic              w_aw_ok;
    logic              w_w_ok;
    logic              w_req;

    assign w_ar_hs = r_arvalid & arready;
    assign w_r_hs  = r_rready & rvalid;
    assign w_aw_hs = r_awvalid & awready;
    assign w_w_hs  = r_wvalid & wready;
    assign w_b_hs  = r_bready & bvalid;
    assign w_aw_ok = r_aw_done | w_aw_hs;
    assign w_w_ok  = r_w_done | w_w_hs;
    assign w_req   = ram_read_enable_i | ram_write_enable_i;

    // Response status and IDs are not checked: no bus-error exception exists on this path.
    logic w_unused_ok;
    assign w_unused_ok = ^{rid, rresp, rlast, bid, bresp};

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (ram_write_enable_i) begin
                    w_next = ST_WR_REQ;
                end else if (ram_read_enable_i) begin
                    w_next = ST_RD_ADDR;
                end
            end
            ST_RD_ADDR: if (w_ar_hs) w_next = ST_RD_DATA;
            ST_RD_DATA: if (w_r_hs) w_next = ST_DONE;
            ST_WR_REQ:  if (w_aw_ok && w_w_ok) w_next = ST_WR_RESP;
            ST_WR_RESP: if (w_b_hs) w_next = ST_DONE;
            // A withdrawn request leaves immediately; a live one waits for MEM to advance.
            ST_DONE:    if (!pipeline_stall_i || !w_req) w_next = ST_IDLE;
            default:    w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_addr  <= '0;
            r_wdata <= '0;
            r_wstrb <= '0;
        end else if (r_state == ST_IDLE) begin
            if (ram_write_enable_i) begin
                r_addr  <= ram_write_addr_i;
                r_wdata <= ram_write_data_i;
                r_wstrb <= ram_write_select_i;
            end else if (ram_read_enable_i) begin
                r_addr  <= ram_read_addr_i;
            end
        end
    end

    // Handshake outputs are registered from the next state so each channel sees clean edges.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b0;
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b0;
            r_bready  <= 1'b0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_rdata   <= '0;
        end else begin
            r_arvalid <= (w_next == ST_RD_ADDR);
            r_rready  <= (w_next == ST_RD_DATA);
            r_bready  <= (w_next == ST_WR_RESP);
            if (r_state == ST_IDLE && w_next == ST_WR_REQ) begin
                r_awvalid <= 1'b1;
                r_wvalid  <= 1'b1;
                r_aw_done <= 1'b0;
                r_w_done  <= 1'b0;
            end else begin
                if (w_aw_hs) begin
                    r_awvalid <= 1'b0;
                    r_aw_done <= 1'b1;
                end
                if (w_w_hs) begin
                    r_wvalid <= 1'b0;
                    r_w_done <= 1'b1;
                end
            end
            if (w_r_hs) begin
                r_rdata <= rdata;
            end
        end
    end

    assign data_stall_o    = w_req & (r_state != ST_DONE);
    assign ram_read_data_o = r_rdata;

    assign arid    = AXI_ID;
    assign araddr  = r_addr;
    assign arlen   = AXI_LEN_1BEAT;
    assign arsize  = AXI_SIZE_WORD;
    assign arburst = AXI_BURST_INCR;
    assign arvalid = r_arvalid;
    assign rready  = r_rready;

    assign awid    = AXI_ID;
    assign awaddr  = r_addr;
    assign awlen   = AXI_LEN_1BEAT;
    assign awsize  = AXI_SIZE_WORD;
    assign awburst = AXI_BURST_INCR;
    assign awvalid = r_awvalid;

    assign wid     = AXI_ID;
    assign wdata   = r_wdata;
    assign wstrb   = r_wstrb;
    assign wlast   = 1'b1;
    assign wvalid  = r_wvalid;
    assign bready  = r_bready;

endmodule
